// File: rtl/gpu_pkg.sv
// Shared constants and FSM state type for the GPU vertex fetch path.
package gpu_pkg;

    localparam int WORDS_PER_VTX = 3;
    localparam int VTX_ADDR_W    = 8;
    localparam int VTX_DATA_W    = 32;
    localparam int WIDX_W        = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAST,
        EMIT,
        FIN
    } vfu_state_t;

endpackage

// File: rtl/vertex_fetch_unit_if.sv
// Command, Avalon-MM read and vertex stream signals of the vertex fetch unit.
interface vertex_fetch_unit_if #(
    parameter int ADDR_W = gpu_pkg::VTX_ADDR_W,
    parameter int DATA_W = gpu_pkg::VTX_DATA_W
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        vtx_count;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic              vtx_valid;
    logic              vtx_ready;
    logic [DATA_W-1:0] vtx_x;
    logic [DATA_W-1:0] vtx_y;
    logic [DATA_W-1:0] vtx_z;

    // The fetch unit side.
    modport master (
        input  start, base_addr, vtx_count, mem_readdata, vtx_ready,
        output busy, done, mem_address, mem_chipselect, mem_write,
               mem_byteenable, mem_clken, vtx_valid, vtx_x, vtx_y, vtx_z
    );

    // Software, RAM and rasteriser side.
    modport slave (
        output start, base_addr, vtx_count, mem_readdata, vtx_ready,
        input  busy, done, mem_address, mem_chipselect, mem_write,
               mem_byteenable, mem_clken, vtx_valid, vtx_x, vtx_y, vtx_z
    );

endinterface

// File: rtl/vertex_fetch_unit_vtx_word_assembler.sv
// Steers RAM read data into x/y/z holding registers using a one-cycle
// delayed copy of the issue strobe and word index.
module vtx_word_assembler
    import gpu_pkg::*;
#(
    parameter int DATA_W = VTX_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [WIDX_W-1:0] widx,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] z
);

    logic              issue_d;
    logic [WIDX_W-1:0] widx_d;

    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge value of issue_d/widx_d, whatever the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_d <= 1'b0;
            widx_d  <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
        end else begin
            issue_d <= issue;
            widx_d  <= widx;
            if (issue_d) begin
                case (widx_d)
                    2'd0:    x <= rdata;
                    2'd1:    y <= rdata;
                    2'd2:    z <= rdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/vertex_fetch_unit.sv
// Avalon-MM read master that fetches 3-word vertex records from the vertex
// RAM and emits them on a valid/ready stream.
module vertex_fetch_unit
    import gpu_pkg::*;
#(
    parameter int ADDR_W = VTX_ADDR_W,
    parameter int DATA_W = VTX_DATA_W
) (
    input logic                 clk,
    input logic                 reset,
    vertex_fetch_unit_if.master bus
);

    vfu_state_t        state;
    vfu_state_t        state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [WIDX_W-1:0] widx;
    logic [7:0]        remaining;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = (bus.vtx_count == 8'd0) ? FIN : FETCH;
            FETCH: if (widx == WIDX_W'(WORDS_PER_VTX - 1)) state_nxt = LAST;
            LAST:  state_nxt = EMIT;
            EMIT:  if (bus.vtx_ready) state_nxt = (remaining == 8'd1) ? FIN : FETCH;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // addr keeps counting across vertices and wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            widx      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.vtx_count != 8'd0) begin
                        addr      <= bus.base_addr;
                        remaining <= bus.vtx_count;
                        widx      <= '0;
                    end
                end
                FETCH: begin
                    addr <= addr + ADDR_W'(1);
                    widx <= widx + WIDX_W'(1);
                end
                EMIT: begin
                    if (bus.vtx_ready) begin
                        remaining <= remaining - 8'd1;
                        widx      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = (state == FETCH) || (state == LAST) || (state == EMIT);
    assign bus.done           = (state == FIN);
    assign bus.mem_address    = addr;
    assign bus.mem_chipselect = (state == FETCH);
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.vtx_valid      = (state == EMIT);

    vtx_word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk   (clk),
        .reset (reset),
        .issue (bus.mem_chipselect),
        .widx  (widx),
        .rdata (bus.mem_readdata),
        .x     (bus.vtx_x),
        .y     (bus.vtx_y),
        .z     (bus.vtx_z)
    );

endmodule

// File: tb/tb_vertex_fetch_unit.sv
// Self-checking bench for vertex_fetch_unit with a behavioural vertex RAM.
module tb_vertex_fetch_unit;
    import gpu_pkg::*;

    localparam logic [31:0] WA = 32'hA5A5_00FE;
    localparam logic [31:0] WB = 32'hB6B6_00FF;
    localparam logic [31:0] WC = 32'hC7C7_0000;

    typedef struct {
        logic [7:0]  base;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vertex_fetch_unit_if vif ();

    vertex_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    // RAM with registered address and unregistered output.
    logic [31:0] ram [256];
    logic [7:0]  ram_aq = 8'd0;
    always @(posedge clk) if (vif.mem_clken) ram_aq <= vif.mem_address;
    assign vif.mem_readdata = ram[ram_aq];

    int errors    = 0;
    int checks    = 0;
    int cs_cnt    = 0;
    int done_cnt  = 0;
    int const_bad = 0;
    logic [7:0] addr_log [$];

    always @(negedge clk) begin
        if (vif.mem_chipselect) begin
            cs_cnt++;
            addr_log.push_back(vif.mem_address);
        end
        if (vif.done) done_cnt++;
        if (vif.mem_write !== 1'b0 || vif.mem_byteenable !== 4'hF || vif.mem_clken !== 1'b1)
            const_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_vtx(input string name, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] z);
        check({name, "_x"}, vif.vtx_x, x);
        check({name, "_y"}, vif.vtx_y, y);
        check({name, "_z"}, vif.vtx_z, z);
    endtask

    // Called at a falling edge; returns just after the edge that samples start.
    task automatic pulse_start(input logic [7:0] b, input logic [7:0] n);
        vif.base_addr = b;
        vif.vtx_count = n;
        vif.start     = 1'b1;
        @(posedge clk);
        #1 vif.start  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vif.vtx_valid && n < 40);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vif.done && n < 40);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, 32'(vif.busy), 32'd0);
        check({name, "_done"}, 32'(vif.done), 32'd0);
        check({name, "_addr"}, 32'(vif.mem_address), 32'd0);
        check({name, "_cs"}, 32'(vif.mem_chipselect), 32'd0);
        check({name, "_valid"}, 32'(vif.vtx_valid), 32'd0);
        check_vtx(name, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        vec_t vecs [4];
        int   n;
        int   d0;
        int   nv;
        int   hold_bad;
        logic [31:0] x3;

        vecs[0] = '{base: 8'd3,   x: 32'd4,          y: 32'd5,          z: 32'd6};
        vecs[1] = '{base: 8'd9,   x: 32'h1000_0009,  y: 32'h1000_000A,  z: 32'h1000_000B};
        vecs[2] = '{base: 8'd100, x: 32'h1000_0064,  y: 32'h1000_0065,  z: 32'h1000_0066};
        vecs[3] = '{base: 8'd253, x: 32'h1000_00FD,  y: WA,             z: WB};

        for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 | 32'(i);
        for (int i = 0; i < 6; i++) ram[i] = 32'(i + 1);
        ram[254] = WA;
        ram[255] = WB;

        vif.start     = 1'b0;
        vif.base_addr = 8'd0;
        vif.vtx_count = 8'd0;
        vif.vtx_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic: two vertices, ready always high
        cs_cnt = 0;
        d0     = done_cnt;
        pulse_start(8'd0, 8'd2);
        wait_valid(n);
        check("basic_lat1", n, 5);
        check("basic_busy", 32'(vif.busy), 32'd1);
        check_vtx("basic_v1", 32'd1, 32'd2, 32'd3);
        wait_valid(n);
        check("basic_lat2", n, 5);
        check_vtx("basic_v2", 32'd4, 32'd5, 32'd6);
        wait_done(n);
        check("basic_done_lat", n, 1);
        check("basic_done_busy", 32'(vif.busy), 32'd0);
        @(negedge clk);
        check("basic_cs_cycles", cs_cnt, 6);
        check("basic_done_cnt", done_cnt - d0, 1);

        // Backpressure: ready low while the first vertex is presented
        vif.vtx_ready = 1'b0;
        pulse_start(8'd0, 8'd2);
        wait_valid(n);
        check("bp_lat1", n, 5);
        cs_cnt   = 0;
        hold_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (vif.vtx_valid !== 1'b1 || vif.vtx_x !== 32'd1 || vif.vtx_y !== 32'd2 ||
                vif.vtx_z !== 32'd3)
                hold_bad++;
        end
        check("bp_hold", hold_bad, 0);
        check("bp_no_cs", cs_cnt, 0);
        vif.vtx_ready = 1'b1;
        wait_valid(n);
        check("bp_lat2", n, 5);
        check_vtx("bp_v2", 32'd4, 32'd5, 32'd6);
        wait_done(n);
        check("bp_done_lat", n, 1);

        // Single-vertex vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            cs_cnt = 0;
            addr_log.delete();
            pulse_start(vecs[i].base, 8'd1);
            wait_valid(n);
            check($sformatf("vec%0d_lat", i), n, 5);
            check_vtx($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].z);
            wait_done(n);
            check($sformatf("vec%0d_done_lat", i), n, 1);
            @(negedge clk);
            check($sformatf("vec%0d_cs", i), cs_cnt, 3);
            check($sformatf("vec%0d_addr0", i),
                  32'((addr_log.size() > 0) ? addr_log[0] : 8'hxx), 32'(vecs[i].base));
        end

        // Zero count: done in C1, no busy, no RAM access
        cs_cnt = 0;
        d0     = done_cnt;
        pulse_start(8'd0, 8'd0);
        @(negedge clk);
        check("zero_done", 32'(vif.done), 32'd1);
        check("zero_busy", 32'(vif.busy), 32'd0);
        @(negedge clk);
        check("zero_cs", cs_cnt, 0);
        check("zero_done_cnt", done_cnt - d0, 1);

        // Start during FETCH is ignored
        d0 = done_cnt;
        pulse_start(8'd0, 8'd3);
        @(negedge clk);
        pulse_start(8'd100, 8'd1);
        nv = 0;
        x3 = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (vif.vtx_valid && vif.vtx_ready) begin
                nv++;
                if (nv == 3) x3 = vif.vtx_x;
            end
            if (vif.done) break;
        end
        check("ign_vertices", nv, 3);
        check("ign_v3_x", x3, 32'h1000_0006);
        @(negedge clk);
        check("ign_done_cnt", done_cnt - d0, 1);

        // Wrap across address 255
        ram[0] = WC;
        cs_cnt = 0;
        d0     = done_cnt;
        addr_log.delete();
        pulse_start(8'd254, 8'd1);
        wait_valid(n);
        check("wrap_lat", n, 5);
        check_vtx("wrap", WA, WB, WC);
        wait_done(n);
        check("wrap_done_lat", n, 1);
        @(negedge clk);
        check("wrap_naddr", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check("wrap_a0", 32'(addr_log[0]), 32'd254);
            check("wrap_a1", 32'(addr_log[1]), 32'd255);
            check("wrap_a2", 32'(addr_log[2]), 32'd0);
        end
        check("wrap_done_cnt", done_cnt - d0, 1);

        // Reset during the second FETCH cycle
        pulse_start(8'd0, 8'd4);
        @(negedge clk);
        @(negedge clk);
        d0    = done_cnt;
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        pulse_start(8'd9, 8'd1);
        wait_valid(n);
        check("rst_after_lat", n, 5);
        check_vtx("rst_after", 32'h1000_0009, 32'h1000_000A, 32'h1000_000B);
        wait_done(n);
        check("rst_after_done_lat", n, 1);
        @(negedge clk);

        check("const_outputs", const_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vertex_fetch_unit.md
Name: vertex_fetch_unit

Overview:
- Avalon-MM read master that sits directly upstream of the rasteriser and reads packed vertex records out of the 256x32 single-port on-chip RAM (GPU vertex buffer).
- Each vertex is 3 consecutive 32-bit words (x, y, z).
- The assembled vertex is emitted on a valid/ready stream.
- Software loads the RAM, then pulses start with base address and vertex count.

Parameters:
ADDR_W, 8, RAM word-address width (256 words)
DATA_W, 32, RAM data width and width of each coordinate
WORDS_PER_VTX, 3, words per vertex record; fixed at 3 for this revision

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle command pulse; sampled only in IDLE
base_addr  in  ADDR_W  word address of first vertex word
vtx_count  in  8  number of vertices to fetch (0 = none)
busy  out  1  high from cycle after accepted start until done cycle (exclusive)
done  out  1  one-cycle pulse when command completes
mem_address  out  ADDR_W  RAM word address
mem_chipselect  out  1  RAM select; high only in FETCH cycles
mem_write  out  1  constant 0
mem_byteenable  out  4  constant 4'hF
mem_clken  out  1  constant 1
mem_readdata  in  DATA_W  RAM read data; valid 1 cycle after address (registered address, unregistered q)
vtx_valid  out  1  output vertex valid
vtx_ready  in  1  downstream accept
vtx_x  out  DATA_W  vertex word 0
vtx_y  out  DATA_W  vertex word 1
vtx_z  out  DATA_W  vertex word 2

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset values: all state registers clear. busy=0, done=0, mem_address=0, mem_chipselect=0, vtx_valid=0, vtx_x/y/z=0. FSM goes to IDLE.
- Reset mid-operation aborts immediately. No done pulse; any in-flight read is discarded.
- FSM states: IDLE, FETCH, LAST, EMIT, FIN.
- IDLE:
  - start=1 and vtx_count=0 -> FIN.
  - start=1 and vtx_count>0 -> FETCH. Latch addr<=base_addr, remaining<=vtx_count, widx<=0.
  - start while not IDLE is ignored.
- FETCH:
  - mem_address=addr, mem_chipselect=1.
  - Each cycle: addr<=addr+1 (mod 256, natural wrap 255->0), widx<=widx+1.
  - After the widx=2 cycle -> LAST.
- Read capture: a 1-cycle delayed copy of (chipselect, widx) steers mem_readdata into x/y/z holding registers. Capture happens at the edge ending the cycle after issue.
- LAST: one cycle, chipselect=0; captures word 2 -> EMIT.
- EMIT:
  - vtx_valid=1; x/y/z stable until handshake.
  - On vtx_valid&vtx_ready: remaining<=remaining-1.
  - If remaining==1 -> FIN, else -> FETCH with widx<=0. addr continues from where it stopped.
  - vtx_ready low holds EMIT indefinitely with no RAM access.
- FIN: done=1 for one cycle, busy=0 -> IDLE. start sampled in FIN is ignored.
- Timing, with start sampled in cycle C0:
  - FETCH in C1..C3, LAST in C4, vtx_valid from C5.
  - Handshake in cycle E: next FETCH at E+1, next vtx_valid at E+5.
  - Final handshake in E: done in E+1.
  - vtx_count=0: done in C1, no RAM access, busy never rises.
- Address arithmetic is ADDR_W-bit modulo. Fetches crossing 255 wrap to 0. A count above 85 re-reads wrapped words by design.
- vtx_valid is never asserted with stale data. vtx_ready while vtx_valid=0 has no effect.

Decomposition:
- Shared package gpu_pkg holds: WORDS_PER_VTX, VTX_ADDR_W, and the FSM state enum (IDLE, FETCH, LAST, EMIT, FIN).
- The x/y/z capture register file with its delayed word-index steering is a natural sub-module: vtx_word_assembler.
- FSM, address counter and vertex counter stay in the top.

Test Plan:
- Basic: RAM[0..5]={1,2,3,4,5,6}, base=0, count=2, ready=1 -> vertex (1,2,3) valid at C5, (4,5,6) valid at C10, done at C11, exactly 6 chipselect cycles.
- Backpressure: same setup, ready low for 7 cycles after first valid -> x/y/z hold (1,2,3), no chipselect while EMIT, second vertex valid 5 cycles after the handshake.
- Wrap: RAM[254]=A, RAM[255]=B, RAM[0]=C, base=254, count=1 -> addresses 254,255,0 issued; vertex (A,B,C); done once.
- Zero count and ignored start: count=0 -> done in C1, busy=0, no chipselect. Then start pulsed mid-fetch of count=3 -> ignored; exactly 3 vertices emitted.
- Reset mid-op: assert reset during the second FETCH of count=4 -> all outputs 0 asynchronously, no done. A new start with base=9, count=1 then returns RAM[9..11] correctly.
- Constant outputs: mem_write=0, mem_byteenable=4'hF, mem_clken=1 in every cycle of all scenarios (assertion).
